// File: rtl/lockstep_write_checker_pkg.sv
// Shared types for the lockstep write checker.
// Record, state and default address constants.
package lockstep_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] FLAG_ADDR_DEF   = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] RESULT_ADDR_DEF = 32'h0000_1004;

    typedef enum logic [1:0] {
        RUN,
        DONE,
        FAULT
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_rec_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lockstep_write_checker_if.sv
// Write-stream bundle between the two cores and the checker.
// master drives the write strobes, slave is the checker.
interface lockstep_write_checker_if
    import lockstep_pkg::*;
    ;

    logic              enable_i;
    logic              we_1_i;
    logic [ADDR_W-1:0] addr_1_i;
    logic [DATA_W-1:0] data_1_i;
    logic              we_2_i;
    logic [ADDR_W-1:0] addr_2_i;
    logic [DATA_W-1:0] data_2_i;

    logic              mismatch_o;
    logic [ADDR_W-1:0] mismatch_addr_o;
    logic              overflow_o;
    logic              timeout_o;
    logic              done_o;
    logic [DATA_W-1:0] result_o;
    logic [15:0]       match_count_o;
    logic              pending_o;

    modport master (
        output enable_i,
        output we_1_i, addr_1_i, data_1_i,
        output we_2_i, addr_2_i, data_2_i,
        input  mismatch_o, mismatch_addr_o,
        input  overflow_o, timeout_o,
        input  done_o, result_o,
        input  match_count_o, pending_o
    );

    modport slave (
        input  enable_i,
        input  we_1_i, addr_1_i, data_1_i,
        input  we_2_i, addr_2_i, data_2_i,
        output mismatch_o, mismatch_addr_o,
        output overflow_o, timeout_o,
        output done_o, result_o,
        output match_count_o, pending_o
    );

endinterface

// File: rtl/lockstep_write_checker_fifo.sv
// Synchronous FIFO of write records.
// A push to a full FIFO is dropped unless a pop frees a slot.
module wr_fifo
    import lockstep_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  wr_rec_t din_i,
    input  logic    pop_i,
    output wr_rec_t dout_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int AW = $clog2(DEPTH);

    wr_rec_t     mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);

    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    assign dout_o = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/lockstep_write_checker.sv
// Compares the two cores' data-memory write streams pair by pair
// and latches sticky fault, result and completion status.
module lockstep_write_checker
    import lockstep_pkg::*;
#(
    parameter int                DEPTH       = 4,
    parameter logic [ADDR_W-1:0] FLAG_ADDR   = FLAG_ADDR_DEF,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = RESULT_ADDR_DEF,
    parameter int                SKEW_MAX    = 16
) (
    input logic clk_i,
    input logic rst_i,
    lockstep_write_checker_if.slave bus
);

    localparam int SW = $clog2(SKEW_MAX + 1);

    state_t            state;
    logic              mismatch_q;
    logic [ADDR_W-1:0] mismatch_addr_q;
    logic              overflow_q;
    logic              timeout_q;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic [15:0]       match_count_q;
    logic [SW-1:0]     skew_cnt;

    wr_rec_t rec_1;
    wr_rec_t rec_2;
    wr_rec_t head_1;
    wr_rec_t head_2;
    logic    full_1;
    logic    full_2;
    logic    empty_1;
    logic    empty_2;

    logic run;
    logic push_1;
    logic push_2;
    logic pop;
    logic ovf_1;
    logic ovf_2;
    logic pair_eq;
    logic one_side;
    logic skew_hit;
    logic done_hit;
    logic fault_any;

    assign run    = (state == RUN);
    assign push_1 = bus.we_1_i && bus.enable_i && run;
    assign push_2 = bus.we_2_i && bus.enable_i && run;
    assign pop    = run && !empty_1 && !empty_2;

    assign rec_1 = '{addr: bus.addr_1_i, data: bus.data_1_i};
    assign rec_2 = '{addr: bus.addr_2_i, data: bus.data_2_i};

    assign ovf_1 = push_1 && full_1 && !pop;
    assign ovf_2 = push_2 && full_2 && !pop;

    assign pair_eq  = (head_1 == head_2);
    assign one_side = run && (empty_1 != empty_2);
    assign skew_hit = one_side &&
                      (skew_cnt == SW'(SKEW_MAX - 1));

    assign done_hit = pop && pair_eq &&
                      (head_1.addr == FLAG_ADDR) &&
                      (head_1.data != '0);

    assign fault_any = ovf_1 || ovf_2 || skew_hit ||
                       (pop && !pair_eq);

    wr_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_1),
        .din_i   (rec_1),
        .pop_i   (pop),
        .dout_o  (head_1),
        .full_o  (full_1),
        .empty_o (empty_1)
    );

    wr_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_2),
        .din_i   (rec_2),
        .pop_i   (pop),
        .dout_o  (head_2),
        .full_o  (full_2),
        .empty_o (empty_2)
    );

    // Everything is frozen once the run leaves RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= RUN;
            mismatch_q      <= 1'b0;
            mismatch_addr_q <= '0;
            overflow_q      <= 1'b0;
            timeout_q       <= 1'b0;
            done_q          <= 1'b0;
            result_q        <= '0;
            match_count_q   <= '0;
            skew_cnt        <= '0;
        end else if (run) begin
            skew_cnt <= one_side ? skew_cnt + SW'(1) : '0;

            if (ovf_1 || ovf_2) begin
                overflow_q <= 1'b1;
            end
            if (skew_hit) begin
                timeout_q <= 1'b1;
            end

            if (pop && pair_eq) begin
                match_count_q <= sat_inc(match_count_q);
                if (head_1.addr == RESULT_ADDR) begin
                    result_q <= head_1.data;
                end
                if (done_hit) begin
                    done_q <= 1'b1;
                end
            end else if (pop) begin
                mismatch_q      <= 1'b1;
                mismatch_addr_q <= head_1.addr;
            end

            if (fault_any) begin
                state <= FAULT;
            end else if (done_hit) begin
                state <= DONE;
            end
        end
    end

    assign bus.mismatch_o      = mismatch_q;
    assign bus.mismatch_addr_o = mismatch_addr_q;
    assign bus.overflow_o      = overflow_q;
    assign bus.timeout_o       = timeout_q;
    assign bus.done_o          = done_q;
    assign bus.result_o        = result_q;
    assign bus.match_count_o   = match_count_q;
    assign bus.pending_o       = !empty_1 || !empty_2;

endmodule

// File: tb/tb_lockstep_write_checker.sv
// Directed bench for lockstep_write_checker.
// Expected status snapshots are queued with the stimulus, then popped.
module tb_lockstep_write_checker;
    import lockstep_pkg::*;

    typedef struct {
        logic        mm;
        logic [31:0] mm_addr;
        logic        ovf;
        logic        to;
        logic        dn;
        logic [31:0] res;
        logic [15:0] mc;
        logic        pend;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    failures = 0;
    snap_t sb[$];
    snap_t e;

    always #5 clk = ~clk;

    lockstep_write_checker_if bus ();

    lockstep_write_checker #(
        .DEPTH    (4),
        .SKEW_MAX (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(
        input logic        w1,
        input logic [31:0] a1,
        input logic [31:0] d1,
        input logic        w2,
        input logic [31:0] a2,
        input logic [31:0] d2
    );
        bus.we_1_i   = w1;
        bus.addr_1_i = a1;
        bus.data_1_i = d1;
        bus.we_2_i   = w2;
        bus.addr_2_i = a2;
        bus.data_2_i = d2;
        tick();
        bus.we_1_i = 1'b0;
        bus.we_2_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic both(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b1, a, d);
    endtask

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_snap();
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        snap_t x;
        x = sb.pop_front();
        chk({tag, ".mismatch"}, 32'(bus.mismatch_o), 32'(x.mm));
        chk({tag, ".mm_addr"}, bus.mismatch_addr_o, x.mm_addr);
        chk({tag, ".overflow"}, 32'(bus.overflow_o), 32'(x.ovf));
        chk({tag, ".timeout"}, 32'(bus.timeout_o), 32'(x.to));
        chk({tag, ".done"}, 32'(bus.done_o), 32'(x.dn));
        chk({tag, ".result"}, bus.result_o, x.res);
        chk({tag, ".match_cnt"}, 32'(bus.match_count_o), 32'(x.mc));
        chk({tag, ".pending"}, 32'(bus.pending_o), 32'(x.pend));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.we_1_i = 1'b0;
        bus.we_2_i = 1'b0;
        tick();
        rst = 1'b0;
        e = '{default: '0};
        expect_snap();
        check(tag);
    endtask

    initial begin
        bus.enable_i = 1'b1;
        bus.we_1_i   = 1'b0;
        bus.addr_1_i = '0;
        bus.data_1_i = '0;
        bus.we_2_i   = 1'b0;
        bus.addr_2_i = '0;
        bus.data_2_i = '0;
        tick();
        do_reset("reset");

        // enable low: writes are ignored
        bus.enable_i = 1'b0;
        both(32'h100, 32'd5);
        bus.enable_i = 1'b1;
        idle(2);
        expect_snap();
        check("enable_off");

        // same-cycle lockstep writes
        both(32'h100, 32'd5);
        both(32'h104, 32'd7);
        e.mc = 16'd2;
        expect_snap();
        idle(2);
        check("lockstep");

        // core 2 lags by three cycles
        do_reset("reset2");
        step(1'b1, 32'h100, 32'd5, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h104, 32'd7, 1'b0, 32'h0, 32'h0);
        idle(1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 32'd5);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 32'd7);
        e.mc = 16'd2;
        expect_snap();
        idle(2);
        check("skewed");

        // divergent data
        do_reset("reset3");
        step(1'b1, 32'h200, 32'd9, 1'b1, 32'h200, 32'd8);
        idle(2);
        e.mm      = 1'b1;
        e.mm_addr = 32'h200;
        expect_snap();
        check("mismatch");
        both(32'h204, 32'd3);
        idle(2);
        expect_snap();
        check("after_fault");

        // result capture and end flag
        do_reset("reset4");
        both(32'h1004, 32'd42);
        both(32'h1000, 32'd1);
        idle(1);
        e.res = 32'd42;
        e.dn  = 1'b1;
        e.mc  = 16'd2;
        expect_snap();
        check("done");
        both(32'h100, 32'd1);
        idle(2);
        expect_snap();
        check("after_done");

        // core 1 alone overflows its FIFO
        do_reset("reset5");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h300 + 32'(4 * i), 32'(i),
                 1'b0, 32'h0, 32'h0);
        end
        e.ovf  = 1'b1;
        e.pend = 1'b1;
        expect_snap();
        check("overflow");

        // single core 1 write times out after SKEW_MAX cycles
        do_reset("reset6");
        step(1'b1, 32'h400, 32'd1, 1'b0, 32'h0, 32'h0);
        idle(15);
        e.pend = 1'b1;
        expect_snap();
        check("skew_15");
        idle(1);
        e.to = 1'b1;
        expect_snap();
        check("skew_16");

        // reset while entries are buffered and mismatch is set
        do_reset("reset7");
        step(1'b1, 32'h200, 32'd9, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h204, 32'd1, 1'b1, 32'h200, 32'd8);
        step(1'b1, 32'h208, 32'd2, 1'b1, 32'h204, 32'd1);
        e.mm      = 1'b1;
        e.mm_addr = 32'h200;
        e.pend    = 1'b1;
        expect_snap();
        check("pre_reset");
        do_reset("mid_reset");
        both(32'h10, 32'd3);
        idle(1);
        e.mc = 16'd1;
        expect_snap();
        check("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
